// File: rtl/sam_mouse.sv
// SAM Coupe mouse: PS/2 mouse receiver, motion/button accumulator and the
// nibble-serial read protocol served on port 0xFFFE.
module sam_mouse #(
  parameter int SEQ_TIMEOUT = 4800,
  parameter int PS2_TIMEOUT = 96000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       sel,
  output logic [7:0] dout,
  output logic       active
);

  localparam int SW = $clog2(SEQ_TIMEOUT + 1);
  localparam int PW = $clog2(PS2_TIMEOUT + 1);

  typedef enum logic [1:0] {
    PKT_B0 = 2'd0,
    PKT_B1 = 2'd1,
    PKT_B2 = 2'd2
  } pkt_state_t;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] sum;
    sum = {a[11], a} + {b[11], b};
    if (sum[12] != sum[11]) begin
      sat_add12 = sum[12] ? 12'h800 : 12'h7FF;
    end else begin
      sat_add12 = sum[11:0];
    end
  endfunction

  logic [1:0]  clk_sync_r, dat_sync_r;
  logic        clk_prev_r;
  logic        ps2_fall_s, ps2_bit_s;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  shift_r, rx_byte_r;
  logic        parity_r, rx_valid_r, rx_err_r;
  logic [PW-1:0] ps2_tmo_r;

  pkt_state_t  state_r, state_nx_s;
  logic        load_b0_s, load_b1_s, pkt_done_s;
  logic [7:4]  b0_hi_r;
  logic [2:0]  b0_btn_r;
  logic [7:0]  b1_r;
  logic [11:0] dx_s, dy_s;

  logic        sel_r, sel_rise_s, snap_s;
  logic [3:0]  idx_r;
  logic [SW-1:0] seq_tmo_r;
  logic [11:0] acc_x_r, acc_y_r, latch_x_r, latch_y_r;
  logic [11:0] base_x_s, base_y_s, acc_x_nx_s, acc_y_nx_s;
  logic [2:0]  buttons_r;
  logic        active_r;
  logic [3:0]  nibble_s;
  logic [7:0]  dout_r;

  // Two-flop synchronisers on the PS/2 lines plus a delayed clock for edge detect
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
      clk_prev_r <= 1'b1;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk};
      dat_sync_r <= {dat_sync_r[0], ps2_data};
      clk_prev_r <= clk_sync_r[1];
    end
  end

  assign ps2_fall_s = clk_prev_r & ~clk_sync_r[1];
  assign ps2_bit_s  = dat_sync_r[1];

  // PS/2 frame receiver: start, 8 data LSB first, odd parity, stop; stalls abort the frame
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      parity_r   <= 1'b0;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      ps2_tmo_r  <= {PW{1'b0}};
    end else begin
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      if (ps2_fall_s) begin
        ps2_tmo_r <= {PW{1'b0}};
        case (bit_cnt_r)
          4'd0: begin
            if (!ps2_bit_s) bit_cnt_r <= 4'd1;
            else            rx_err_r  <= 1'b1;
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            shift_r   <= {ps2_bit_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
          4'd9: begin
            parity_r  <= ps2_bit_s;
            bit_cnt_r <= 4'd10;
          end
          4'd10: begin
            bit_cnt_r <= 4'd0;
            if (ps2_bit_s && odd_parity_ok(shift_r, parity_r)) begin
              rx_byte_r  <= shift_r;
              rx_valid_r <= 1'b1;
            end else begin
              rx_err_r <= 1'b1;
            end
          end
          default: bit_cnt_r <= 4'd0;
        endcase
      end else if (bit_cnt_r != 4'd0) begin
        if (ps2_tmo_r == PW'(PS2_TIMEOUT)) begin
          bit_cnt_r <= 4'd0;
          ps2_tmo_r <= {PW{1'b0}};
        end else begin
          ps2_tmo_r <= ps2_tmo_r + PW'(1);
        end
      end else begin
        ps2_tmo_r <= {PW{1'b0}};
      end
    end
  end

  // Packet state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_r <= PKT_B0;
    else        state_r <= state_nx_s;
  end

  // Packet sequencing; a header byte must have bit 3 set to start a packet
  always_comb begin
    state_nx_s = state_r;
    load_b0_s  = 1'b0;
    load_b1_s  = 1'b0;
    pkt_done_s = 1'b0;
    case (state_r)
      PKT_B0: begin
        if (rx_valid_r && rx_byte_r[3]) begin
          state_nx_s = PKT_B1;
          load_b0_s  = 1'b1;
        end else begin
          state_nx_s = PKT_B0;
        end
      end
      PKT_B1: begin
        if (rx_err_r) begin
          state_nx_s = PKT_B0;
        end else if (rx_valid_r) begin
          state_nx_s = PKT_B2;
          load_b1_s  = 1'b1;
        end else begin
          state_nx_s = PKT_B1;
        end
      end
      PKT_B2: begin
        if (rx_err_r) begin
          state_nx_s = PKT_B0;
        end else if (rx_valid_r) begin
          state_nx_s = PKT_B0;
          pkt_done_s = 1'b1;
        end else begin
          state_nx_s = PKT_B2;
        end
      end
      default: state_nx_s = PKT_B0;
    endcase
  end

  // Packet byte holding registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      b0_hi_r  <= 4'h0;
      b0_btn_r <= 3'b000;
      b1_r     <= 8'h00;
    end else begin
      if (load_b0_s) begin
        b0_hi_r  <= rx_byte_r[7:4];
        b0_btn_r <= rx_byte_r[2:0];
      end
      if (load_b1_s) b1_r <= rx_byte_r;
    end
  end

  // 9-bit deltas sign-extended to 12 bits; an overflowed axis contributes nothing
  assign dx_s = b0_hi_r[6] ? 12'h000 : {{4{b0_hi_r[4]}}, b1_r};
  assign dy_s = b0_hi_r[7] ? 12'h000 : {{4{b0_hi_r[5]}}, rx_byte_r};

  assign sel_rise_s = sel & ~sel_r;
  assign snap_s     = sel_rise_s & (idx_r == 4'd1);

  // Snapshot clears the accumulators; a packet landing the same cycle adds onto zero
  always_comb begin
    base_x_s = snap_s ? 12'h000 : acc_x_r;
    base_y_s = snap_s ? 12'h000 : acc_y_r;
    if (pkt_done_s) begin
      acc_x_nx_s = sat_add12(base_x_s, dx_s);
      acc_y_nx_s = sat_add12(base_y_s, dy_s);
    end else begin
      acc_x_nx_s = base_x_s;
      acc_y_nx_s = base_y_s;
    end
  end

  // Accumulators, read latches, buttons and activity flag
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acc_x_r   <= 12'h000;
      acc_y_r   <= 12'h000;
      latch_x_r <= 12'h000;
      latch_y_r <= 12'h000;
      buttons_r <= 3'b000;
      active_r  <= 1'b0;
    end else begin
      acc_x_r <= acc_x_nx_s;
      acc_y_r <= acc_y_nx_s;
      if (snap_s) begin
        latch_x_r <= acc_x_r;
        latch_y_r <= acc_y_r;
      end
      if (pkt_done_s) begin
        buttons_r <= b0_btn_r;
        active_r  <= 1'b1;
      end
    end
  end

  // Nibble served at the current read index
  always_comb begin
    nibble_s = 4'hF;
    case (idx_r)
      4'd1:    nibble_s = {1'b1, ~buttons_r[2], ~buttons_r[1], ~buttons_r[0]};
      4'd2:    nibble_s = latch_y_r[11:8];
      4'd3:    nibble_s = latch_y_r[7:4];
      4'd4:    nibble_s = latch_y_r[3:0];
      4'd5:    nibble_s = latch_x_r[11:8];
      4'd6:    nibble_s = latch_x_r[7:4];
      4'd7:    nibble_s = latch_x_r[3:0];
      default: nibble_s = 4'hF;
    endcase
  end

  // Read sequencer: a sel edge serves and advances the index, beating a same-cycle timeout
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sel_r     <= 1'b0;
      idx_r     <= 4'd0;
      seq_tmo_r <= {SW{1'b0}};
      dout_r    <= 8'hFF;
    end else begin
      sel_r <= sel;
      if (sel_rise_s) begin
        idx_r     <= (idx_r == 4'd8) ? 4'd0 : idx_r + 4'd1;
        seq_tmo_r <= SW'(SEQ_TIMEOUT);
      end else if (seq_tmo_r == SW'(1)) begin
        idx_r     <= 4'd0;
        seq_tmo_r <= {SW{1'b0}};
      end else if (seq_tmo_r != {SW{1'b0}}) begin
        seq_tmo_r <= seq_tmo_r - SW'(1);
      end
      if (!sel) begin
        dout_r <= 8'hFF;
      end else if (sel_rise_s) begin
        dout_r <= {4'hF, nibble_s};
      end
    end
  end

  assign dout   = dout_r;
  assign active = active_r;

endmodule

// File: tb/tb_sam_mouse.sv
// Self-checking bench for sam_mouse: PS/2 byte driver, read driver and a
// behavioural model of the mouse protocol (signed ints, cycle-time timeout).
module tb_sam_mouse;

  localparam int SEQ_T = 300;
  localparam int PS2_T = 2000;
  localparam int HALF  = 60;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] dout;
  logic       active;

  sam_mouse #(.SEQ_TIMEOUT(SEQ_T), .PS2_TIMEOUT(PS2_T)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .sel     (sel),
    .dout    (dout),
    .active  (active)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int         m_acc_x, m_acc_y, m_lat_x, m_lat_y, m_idx, m_pkt, last_rise;
  bit         have_last, m_active;
  logic [2:0] m_btn;
  logic [7:0] mb0, mb1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int clamp12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic model_reset();
    m_acc_x = 0; m_acc_y = 0; m_lat_x = 0; m_lat_y = 0;
    m_idx = 0; m_pkt = 0; last_rise = 0; have_last = 0;
    m_active = 0; m_btn = 3'b000; mb0 = 8'h00; mb1 = 8'h00;
  endtask

  task automatic model_rx(input logic [7:0] b, input bit ok);
    int dx, dy;
    if (!ok) begin
      m_pkt = 0;
    end else if (m_pkt == 0) begin
      if (b[3]) begin mb0 = b; m_pkt = 1; end
    end else if (m_pkt == 1) begin
      mb1 = b; m_pkt = 2;
    end else begin
      dx = mb0[6] ? 0 : (mb0[4] ? int'(mb1) - 256 : int'(mb1));
      dy = mb0[7] ? 0 : (mb0[5] ? int'(b) - 256 : int'(b));
      m_acc_x = clamp12(m_acc_x + dx);
      m_acc_y = clamp12(m_acc_y + dy);
      m_btn = mb0[2:0];
      m_active = 1;
      m_pkt = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic [10:0] fr;
    logic par;
    par = ~^b;
    if (bad_par) par = ~par;
    fr = {1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = fr[i];
      #HALF ps2_clk = 1'b0;
      #HALF ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    #(4 * HALF);
    model_rx(b, !bad_par);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  // one CPU read; gap>0 places the sel edge exactly gap cycles after the previous one
  task automatic do_read(input int gap);
    int rise, idx;
    logic [3:0] nib;
    logic [11:0] lx, ly;
    @(posedge clk_sys); #1;
    while (have_last && gap > 0 && cyc + 1 < last_rise + gap) begin
      @(posedge clk_sys); #1;
    end
    sel = 1'b1;
    rise = cyc + 1;
    if (have_last && rise - last_rise > SEQ_T) m_idx = 0;
    have_last = 1;
    last_rise = rise;
    idx = m_idx;
    lx = 12'(m_lat_x);
    ly = 12'(m_lat_y);
    case (m_idx)
      1: begin
        nib = {1'b1, ~m_btn[2], ~m_btn[1], ~m_btn[0]};
        m_lat_x = m_acc_x; m_lat_y = m_acc_y;
        m_acc_x = 0; m_acc_y = 0;
      end
      2: nib = ly[11:8];
      3: nib = ly[7:4];
      4: nib = ly[3:0];
      5: nib = lx[11:8];
      6: nib = lx[7:4];
      7: nib = lx[3:0];
      default: nib = 4'hF;
    endcase
    m_idx = (m_idx == 8) ? 0 : m_idx + 1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check($sformatf("read_idx%0d", idx), dout, {4'hF, nib});
    @(posedge clk_sys); #1;
    sel = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("dout_idle", dout, 8'hFF);
  endtask

  task automatic read_seq();
    for (int i = 0; i < 9; i++) do_read(0);
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    model_reset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset_dout", dout, 8'hFF);
    check("reset_active", {7'b0, active}, 8'h00);
    rst_n = 1'b1;

    // basic packet: +5/+3, no buttons
    send_pkt(8'h08, 8'h05, 8'h03);
    check("active_set", {7'b0, active}, {7'b0, m_active});
    read_seq();

    // left button, dx = -2; second sequence sees cleared accumulators
    send_pkt(8'h19, 8'hFE, 8'h00);
    read_seq();
    read_seq();

    // header without bit 3 is discarded
    send_byte(8'h00, 1'b0);
    send_pkt(8'h08, 8'h01, 8'h01);
    read_seq();

    // bad parity in B1 drops the partial packet
    send_byte(8'h08, 1'b0);
    send_byte(8'h02, 1'b1);
    send_pkt(8'h0A, 8'h03, 8'h04);
    read_seq();

    // three reads, idle past the timeout, reads restart at index 0
    send_pkt(8'h28, 8'h07, 8'hF0);
    do_read(0); do_read(0); do_read(0);
    do_read(SEQ_T + 1);
    read_seq();

    // timeout boundary: exactly SEQ_T continues the sequence, SEQ_T+1 restarts it
    do_read(SEQ_T);
    do_read(SEQ_T);
    do_read(SEQ_T + 1);
    do_read(SEQ_T + 1);

    // positive and negative saturation
    for (int i = 0; i < 20; i++) send_pkt(8'h08, 8'h7F, 8'h00);
    read_seq();
    for (int i = 0; i < 17; i++) send_pkt(8'h38, 8'h80, 8'h80);
    read_seq();

    // stalled partial frame is abandoned before the next packet
    for (int i = 0; i < 5; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'b1;
      #HALF ps2_clk = 1'b0;
      #HALF ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    #((PS2_T + 200) * 10);
    send_pkt(8'h0C, 8'h11, 8'h22);
    read_seq();

    // randomised packets with junk headers and overflow flags
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        r0 = 8'($urandom);
        r0[3] = 1'b0;
        send_byte(r0, 1'b0);
      end
      r0 = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 3) != 0) r0[7:6] = 2'b00;
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      send_pkt(r0, r1, r2);
      if ($urandom_range(0, 1) == 1) read_seq();
    end
    read_seq();

    // asynchronous reset mid-sequence
    send_pkt(8'h09, 8'h10, 8'h20);
    do_read(0); do_read(0); do_read(0);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_dout", dout, 8'hFF);
    check("async_rst_active", {7'b0, active}, 8'h00);
    model_reset();
    @(negedge clk_sys);
    rst_n = 1'b1;
    read_seq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
